// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// State encoding, frame geometry and the idle line level.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PARITY    = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_HIGH = 3'd5
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_checker_parity_acc.sv
// Running XOR over received data bits.
// The first bit of a frame reloads the accumulator.
module rx_parity_acc
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic bit_in,
   input  logic first,
   output logic acc
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= 1'b0;
      end else if (en) begin
         acc <= first ? bit_in : (acc ^ bit_in);
      end
   end

endmodule

// File: rtl/uart_rx_checker.sv
// Oversampling UART receiver with parity and framing checks.
// Define UART_RX_PARITY_EN to add the parity bit to the frame.
module uart_rx_checker
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   input  logic                 parity_odd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   localparam logic [2:0] ST_IDLE      = RX_IDLE;
   localparam logic [2:0] ST_START     = RX_START;
   localparam logic [2:0] ST_DATA      = RX_DATA;
   localparam logic [2:0] ST_STOP      = RX_STOP;
   localparam logic [2:0] ST_WAIT_HIGH = RX_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY    = RX_PARITY;
   localparam logic [2:0] ST_AFTER_DAT = RX_PARITY;
`else
   localparam logic [2:0] ST_AFTER_DAT = RX_STOP;
`endif

   logic [1:0]           sync_q;
   logic [1:0]           fill_q;
   logic                 armed_q;
   logic                 line;
   logic [2:0]           state_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 at_end;
   logic                 acc_en;
   logic                 acc;
   logic                 perr_q;

   assign line   = sync_q[1];
   assign at_end = (cnt_q == CNT_END);
   assign busy   = (state_q != ST_IDLE);
   assign acc_en = baud_tick && (state_q == ST_DATA) && at_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= {2{UART_IDLE_LEVEL}};
         fill_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], rx_in};
         fill_q <= {fill_q[0], 1'b1};
      end
   end

   // Reset forces the synchronizer high, so only a real high level
   // seen after the pipeline refills may arm start detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         armed_q <= 1'b0;
      end else if (fill_q[1] && line == UART_IDLE_LEVEL) begin
         armed_q <= 1'b1;
      end
   end

   rx_parity_acc u_par (
      .clk    (clk),
      .rstn   (rstn),
      .en     (acc_en),
      .bit_in (line),
      .first  (idx_q == '0),
      .acc    (acc)
   );

`ifdef UART_RX_PARITY_EN
   logic podd_q;
   logic pend_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         podd_q <= 1'b0;
         pend_q <= 1'b0;
      end else if (baud_tick) begin
         if (state_q == ST_START && cnt_q == CNT_MID) begin
            podd_q <= parity_odd;
            pend_q <= 1'b0;
         end else if (state_q == ST_PARITY && at_end) begin
            pend_q <= line ^ acc ^ podd_q;
         end
      end
   end

   assign perr_q = pend_q;
`else
   logic unused_par;

   assign unused_par = ^{acc, parity_odd};
   assign perr_q     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (baud_tick) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (armed_q && line != UART_IDLE_LEVEL) begin
                     cnt_q   <= '0;
                     state_q <= ST_START;
                  end
               end
               ST_START: begin
                  if (cnt_q == CNT_MID) begin
                     cnt_q <= '0;
                     idx_q <= '0;
                     if (line == UART_IDLE_LEVEL) begin
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (at_end) begin
                     cnt_q   <= '0;
                     idx_q   <= idx_q + 1'b1;
                     shift_q <= {line, shift_q[DATA_BITS-1:1]};
                     if (idx_q == IDX_LAST) begin
                        state_q <= ST_AFTER_DAT;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  if (at_end) begin
                     cnt_q   <= '0;
                     state_q <= ST_STOP;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
               // The stop sample lands mid-bit; a good stop returns
               // to IDLE here so the next edge is caught early.
               ST_STOP: begin
                  if (at_end) begin
                     cnt_q      <= '0;
                     rx_data    <= shift_q;
                     rx_valid   <= 1'b1;
                     frame_err  <= !line;
                     parity_err <= perr_q;
                     if (line == UART_IDLE_LEVEL) begin
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_WAIT_HIGH;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_WAIT_HIGH: begin
                  if (line == UART_IDLE_LEVEL) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_checker.sv
// Randomized frame bench for uart_rx_checker with a queue-based model.
// Works with or without UART_RX_PARITY_EN defined.
module tb_uart_rx_checker;
   import uart_pkg::*;

   localparam int OS = UART_OVERSAMPLE;
   localparam int DB = UART_DATA_BITS;
   localparam int TD = 3;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          baud_tick = 1'b0;
   logic          rx_in = 1'b1;
   logic          parity_odd = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          parity_err;
   logic          frame_err;
   logic          busy;

   typedef struct {
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
   } exp_t;

   exp_t          q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_valid = 0;
   logic [DB-1:0] last_data = '0;
   logic [DB-1:0] cap_data = '0;
   logic          cap_perr = 1'b0;
   logic          cap_ferr = 1'b0;
   logic          prev_valid = 1'b0;

   uart_rx_checker dut (
      .clk        (clk),
      .rstn       (rstn),
      .baud_tick  (baud_tick),
      .rx_in      (rx_in),
      .parity_odd (parity_odd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         baud_tick = (div == TD - 1);
         div = (div + 1) % TD;
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Compare process: every cycle, outputs against the model queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk("rst_valid", 32'(rx_valid), 0);
            chk("rst_data", 32'(rx_data), 0);
            chk("rst_perr", 32'(parity_err), 0);
            chk("rst_ferr", 32'(frame_err), 0);
            chk("rst_busy", 32'(busy), 0);
            last_data = '0;
            prev_valid = 1'b0;
         end else if (rx_valid) begin
            n_valid++;
            chk("valid_single_clk", 32'(prev_valid), 0);
            chk("valid_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("data", 32'(rx_data), 32'(e.data));
               chk("parity_err", 32'(parity_err), 32'(e.perr));
               chk("frame_err", 32'(frame_err), 32'(e.ferr));
               last_data = e.data;
            end
            cap_data = rx_data;
            cap_perr = parity_err;
            cap_ferr = frame_err;
            prev_valid = 1'b1;
         end else begin
            chk("data_hold", 32'(rx_data), 32'(last_data));
            prev_valid = 1'b0;
         end
      end
   end

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (baud_tick !== 1'b1);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      ticks(OS);
   endtask

   function automatic logic good_par(input logic [DB-1:0] d, input logic po);
      return (^d) ^ po;
   endfunction

   task automatic send_frame(input logic [DB-1:0] d, input logic pb,
                             input logic sb, input logic po);
      exp_t e;
      parity_odd = po;
      e.data = d;
      e.perr = PAR_EN & (pb != good_par(d, po));
      e.ferr = !sb;
      q.push_back(e);
      send_bit(1'b0);
      // Must be ignored: the mode was latched mid start bit.
      parity_odd = 1'($urandom_range(0, 1));
      for (int i = 0; i < DB; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(pb);
      send_bit(sb);
   endtask

   initial begin
      int nv;
      logic [DB-1:0] d;
      logic po, pb, sb;

      #1;
      repeat (5) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_data", 32'(rx_data), 0);
      rstn = 1'b1;
      ticks(2 * OS);

      nv = n_valid;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      ticks(OS);
      chk("even_count", n_valid, nv + 1);
      chk("even_data", 32'(cap_data), 32'hA5);
      chk("even_perr", 32'(cap_perr), 0);
      chk("even_ferr", 32'(cap_ferr), 0);

      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      ticks(OS);
      chk("odd_bad_data", 32'(cap_data), 32'hA5);
      chk("odd_bad_perr", 32'(cap_perr), 32'(PAR_EN));
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      ticks(OS);
      chk("odd_good_perr", 32'(cap_perr), 0);

      nv = n_valid;
      send_frame(8'h3C, good_par(8'h3C, 1'b0), 1'b0, 1'b0);
      ticks(2 * OS);
      chk("break_busy", 32'(busy), 1);
      chk("break_ferr", 32'(cap_ferr), 1);
      chk("break_data", 32'(cap_data), 32'h3C);
      rx_in = 1'b1;
      ticks(OS);
      chk("break_busy_clear", 32'(busy), 0);
      chk("break_one_valid", n_valid, nv + 1);

      nv = n_valid;
      rx_in = 1'b0;
      ticks(4);
      chk("glitch_busy", 32'(busy), 1);
      rx_in = 1'b1;
      ticks(OS);
      chk("glitch_idle", 32'(busy), 0);
      chk("glitch_no_valid", n_valid, nv);

      nv = n_valid;
      send_frame(8'h00, good_par(8'h00, 1'b0), 1'b1, 1'b0);
      send_frame(8'hFF, good_par(8'hFF, 1'b0), 1'b1, 1'b0);
      send_frame(8'h55, good_par(8'h55, 1'b0), 1'b1, 1'b0);
      ticks(OS);
      chk("b2b_count", n_valid, nv + 3);
      chk("b2b_last", 32'(cap_data), 32'h55);

      nv = n_valid;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      rx_in = 1'b0;
      ticks(OS / 2);
      rstn = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_data", 32'(rx_data), 0);
      rstn = 1'b1;
      ticks(2 * OS);
      chk("midrst_no_restart", 32'(busy), 0);
      rx_in = 1'b1;
      ticks(2 * OS);
      send_frame(8'h7E, good_par(8'h7E, 1'b0), 1'b1, 1'b0);
      ticks(OS);
      chk("midrst_count", n_valid, nv + 1);
      chk("midrst_data_7e", 32'(cap_data), 32'h7E);

      for (int k = 0; k < 16; k++) begin
         d  = DB'($urandom);
         po = 1'($urandom_range(0, 1));
         pb = good_par(d, po) ^ ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 5) != 0);
         send_frame(d, pb, sb, po);
         if (!sb) begin
            ticks($urandom_range(1, OS));
            rx_in = 1'b1;
            ticks(OS + 2);
         end else begin
            ticks($urandom_range(0, 2 * OS));
         end
      end

      ticks(2 * OS);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
